// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: master ids, arbiter states,
// data_mem MemOp encodings and small helpers used by the arbiter datapath.
package dmem_arbiter_pkg;

  // Master identifier: 0 = CPU load/store path, 1 = secondary reader/writer.
  typedef logic [0:0] mst_id_t;

  localparam mst_id_t MST0 = 1'b0;
  localparam mst_id_t MST1 = 1'b1;

  // Arbiter state: free arbitration, or port held by master 0 / master 1.
  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  // data_mem access size/sign encoding (funct3 style).
  typedef enum logic [2:0] {
    MEMOP_LB  = 3'b000,
    MEMOP_LH  = 3'b001,
    MEMOP_LW  = 3'b010,
    MEMOP_LBU = 3'b100,
    MEMOP_LHU = 3'b101
  } memop_e;

  // One-hot grant / valid vector for a master id.
  function automatic logic [1:0] mst_onehot(input mst_id_t id);
    return (id == MST1) ? 2'b10 : 2'b01;
  endfunction

  // The master that is not `id`.
  function automatic mst_id_t mst_other(input mst_id_t id);
    return (id == MST1) ? MST0 : MST1;
  endfunction

  // Lock state that corresponds to a master id.
  function automatic arb_state_e lock_state(input mst_id_t id);
    return (id == MST1) ? LOCK1 : LOCK0;
  endfunction

endpackage

// File: rtl/dmem_rd_tagpipe.sv
// Read-return tracker: a DEPTH-deep shift register of (valid, master id)
// aligned with the data_mem read latency, so each return can be steered
// back to the master that issued it. Cleared by clr, which drops any
// reads still in flight.
module dmem_rd_tagpipe
  import dmem_arbiter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    clr,
  input  logic    push_i,
  input  mst_id_t id_i,
  output logic    valid_o,
  output mst_id_t id_o
);

  logic [DEPTH-1:0] vld_q;
  mst_id_t          id_q [DEPTH];

  // Shift valid/id one stage per cycle; stage 0 takes the newly accepted read.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i] <= MST0;
      end
    end else begin
      vld_q[0] <= push_i;
      id_q[0]  <= id_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
    end
  end

  assign valid_o = vld_q[DEPTH-1];
  assign id_o    = id_q[DEPTH-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of the single data_mem port.
//
// Handshake: a beat transfers in the cycle where m_req[n] & m_gnt[n] are
// both high. The grant is computed combinationally from registered state
// and the current m_req, so a master never sees a grant in a cycle where
// it is not requesting, and dropping m_req simply forfeits that cycle.
// Reads return m_rvalid[n] for exactly one cycle, in issue order.
//
// Arbitration is round-robin (PRIO_MODE=0) or master-0 priority with a
// starvation guard for master 1 (PRIO_MODE=1). A master may hold the port
// with m_lock for at most LOCK_MAX consecutive beats; when the limit cuts
// a lock short, the other master gets the next beat if it is requesting.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int RD_LAT    = 1,
  parameter int PRIO_MODE = 0,
  parameter int MAX_WAIT  = 8,
  parameter int LOCK_MAX  = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [1:0]       m_req,
  input  logic [1:0]       m_lock,
  input  logic [1:0]       m_we,
  input  logic [1:0][31:0] m_addr,
  input  logic [1:0][31:0] m_wdata,
  input  logic [1:0][2:0]  m_memop,
  output logic [1:0]       m_gnt,
  output logic [1:0]       m_rvalid,
  output logic [31:0]      m_rdata,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [2:0]       mem_memop,
  output logic             mem_we,
  input  logic [31:0]      mem_rdata,
  output arb_state_e       dbg_state_o
);

  localparam int WAIT_W   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam int LOCK_W   = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);
  localparam int PIPE_LAT = (RD_LAT < 1) ? 1 : RD_LAT;

  // Registered arbitration state.
  arb_state_e        state_q;
  mst_id_t           rr_ptr_q;     // master favoured on a round-robin tie
  logic              force_q;      // one-shot grant after a lock was cut short
  mst_id_t           force_id_q;
  logic [LOCK_W-1:0] lock_cnt_q;   // beats already done in the current lock
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_d;

  // Last command presented to data_mem, held while nobody is granted.
  logic [31:0] last_addr_q;
  logic [31:0] last_wdata_q;
  logic [2:0]  last_memop_q;

  logic [1:0] gnt_c;
  mst_id_t    win_c;
  logic       starve_c;
  logic       accept;
  logic       rd_push;
  logic       pipe_vld;
  mst_id_t    pipe_id;

  assign starve_c = (PRIO_MODE != 0) && (wait_cnt_q == WAIT_W'(MAX_WAIT));

  // Zero-cycle winner selection from registered state and current requests.
  always_comb begin
    win_c = MST0;
    gnt_c = 2'b00;
    unique case (state_q)
      LOCK0: begin
        win_c = MST0;
        gnt_c = {1'b0, m_req[0]};
      end
      LOCK1: begin
        win_c = MST1;
        gnt_c = {m_req[1], 1'b0};
      end
      default: begin
        if (force_q && m_req[force_id_q]) begin
          win_c = force_id_q;
        end else if (PRIO_MODE != 0) begin
          if (starve_c && m_req[1]) begin
            win_c = MST1;
          end else if (m_req[0]) begin
            win_c = MST0;
          end else begin
            win_c = MST1;
          end
        end else begin
          if (&m_req) begin
            win_c = rr_ptr_q;
          end else if (m_req[0]) begin
            win_c = MST0;
          end else begin
            win_c = MST1;
          end
        end
        if (|m_req) begin
          gnt_c = mst_onehot(win_c);
        end
      end
    endcase
  end

  // Nothing is granted while reset is held, even with requests pending.
  assign m_gnt   = clr ? 2'b00 : gnt_c;
  assign accept  = |m_gnt;
  assign rd_push = accept && !m_we[win_c];

  // data_mem command mirrors the winner; otherwise hold the last command.
  assign mem_addr    = accept ? m_addr[win_c]  : last_addr_q;
  assign mem_wdata   = accept ? m_wdata[win_c] : last_wdata_q;
  assign mem_memop   = accept ? m_memop[win_c] : last_memop_q;
  assign mem_we      = accept && m_we[win_c];
  assign dbg_state_o = state_q;

  // Arbitration / lock FSM, round-robin pointer and post-lock fairness grant.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= ARB;
      rr_ptr_q   <= MST0;
      force_q    <= 1'b0;
      force_id_q <= MST0;
      lock_cnt_q <= '0;
    end else begin
      unique case (state_q)
        LOCK0, LOCK1: begin
          if (!accept) begin
            // Lock owner stopped requesting: release the port.
            state_q    <= ARB;
            lock_cnt_q <= '0;
          end else if (!m_lock[win_c]) begin
            state_q    <= ARB;
            lock_cnt_q <= '0;
          end else if (lock_cnt_q == LOCK_W'(LOCK_MAX - 1)) begin
            // Beat budget exhausted: hand the next beat to the other master.
            state_q    <= ARB;
            lock_cnt_q <= '0;
            force_q    <= 1'b1;
            force_id_q <= mst_other(win_c);
          end else begin
            lock_cnt_q <= lock_cnt_q + 1'b1;
          end
        end
        default: begin
          force_q <= 1'b0;
          if (accept) begin
            rr_ptr_q <= mst_other(win_c);
            if (m_lock[win_c]) begin
              if (LOCK_MAX <= 1) begin
                force_q    <= 1'b1;
                force_id_q <= mst_other(win_c);
              end else begin
                state_q    <= lock_state(win_c);
                lock_cnt_q <= LOCK_W'(1);
              end
            end
          end
        end
      endcase
    end
  end

  // Starvation counter: cycles master 1 waits; cleared by a grant or an idle cycle.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (PRIO_MODE == 0) begin
      wait_cnt_d = '0;
    end else if (!m_req[1] || m_gnt[1]) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_W'(MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Remember the last accepted command so mem_* stay stable when idle.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      last_addr_q  <= '0;
      last_wdata_q <= '0;
      last_memop_q <= '0;
    end else if (accept) begin
      last_addr_q  <= m_addr[win_c];
      last_wdata_q <= m_wdata[win_c];
      last_memop_q <= m_memop[win_c];
    end
  end

  dmem_rd_tagpipe #(
    .DEPTH (PIPE_LAT)
  ) u_tagpipe (
    .clk     (clk),
    .clr     (clr),
    .push_i  (rd_push),
    .id_i    (win_c),
    .valid_o (pipe_vld),
    .id_o    (pipe_id)
  );

  generate
    if (PIPE_LAT == 1) begin : g_rd_comb
      // Single-cycle memory: steer the return straight through.
      assign m_rvalid = pipe_vld ? mst_onehot(pipe_id) : 2'b00;
      assign m_rdata  = pipe_vld ? mem_rdata : 32'h0;
    end else begin : g_rd_reg
      logic [1:0]  rvalid_q;
      logic [31:0] rdata_q;

      // Longer memory latency: register the return to keep the path short.
      always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
          rvalid_q <= 2'b00;
          rdata_q  <= '0;
        end else begin
          rvalid_q <= pipe_vld ? mst_onehot(pipe_id) : 2'b00;
          rdata_q  <= pipe_vld ? mem_rdata : 32'h0;
        end
      end

      assign m_rvalid = rvalid_q;
      assign m_rdata  = rdata_q;
    end
  endgenerate

endmodule
